alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `MIPSALU` instance between two requesters, for example the integer pipeline and a debug/test port. It accepts MIPS R-type function codes with operands over a valid/ready handshake. It decodes each function code to a 4-bit ALU control code and drives the shared ALU for one cycle. It captures the result and Zero flag and returns them on a single tagged response channel with back-pressure.

---
 rtl/alu_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer sharing one combinational
// MIPS ALU between two requesters. Each accepted operation is decoded to an
// ALU control code, driven to the ALU for one EXEC cycle, and its result is
// returned on a single tagged response channel with back-pressure.
//
// Optional feature macro: ALU_ARB_ERR_EN
//   defined   - unsupported function codes skip EXEC and answer directly with
//               resp_err=1, resp_result=0, resp_zero=1 (1-cycle latency).
//   undefined - resp_err is tied low; unsupported codes run through the ALU
//               with control code 15.
`timescale 1ns/1ps

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [5:0]       req0_funct,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [5:0]       req1_funct,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,

    output logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Control code the ALU treats as "no operation" (result 0, Zero 1).
    localparam logic [3:0] CTL_UNSUPPORTED = 4'd15;

    // MIPS R-type function code to 4-bit ALU control code.
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        logic [3:0] ctl;
        case (funct)
            6'd32:   ctl = 4'd2;   // add
            6'd34:   ctl = 4'd6;   // sub
            6'd36:   ctl = 4'd0;   // and
            6'd37:   ctl = 4'd1;   // or
            6'd39:   ctl = 4'd12;  // nor
            6'd42:   ctl = 4'd7;   // slt
            default: ctl = CTL_UNSUPPORTED;
        endcase
        return ctl;
    endfunction

    // Registered state
    state_t             state_q,      state_d;
    logic               last_q,       last_d;
    logic [3:0]         ctl_q,        ctl_d;
    logic [WIDTH-1:0]   a_q,          a_d;
    logic [WIDTH-1:0]   b_q,          b_d;
    logic               id_q,         id_d;
    logic               resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   result_q,     result_d;
    logic               zero_q,       zero_d;
`ifdef ALU_ARB_ERR_EN
    logic               err_q,        err_d;
`endif

    // Arbitration terms
    logic               any_valid;
    logic               grant;
    logic               accept;
    logic [5:0]         sel_funct;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [3:0]         sel_ctl;

    // Round-robin grant: on a tie the requester that did not win last time wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = req1_valid;
        end
        accept    = (state_q == ST_IDLE) && any_valid;
        sel_funct = grant ? req1_funct : req0_funct;
        sel_a     = grant ? req1_a     : req0_a;
        sel_b     = grant ? req1_b     : req0_b;
        sel_ctl   = decode_funct(sel_funct);
    end

    // Ready handshakes; held low while reset is asserted so nothing is
    // accepted during reset even though the FSM already sits in IDLE.
    always_comb begin
        req0_ready = !reset && (state_q == ST_IDLE) && req0_valid && (grant == 1'b0);
        req1_ready = !reset && (state_q == ST_IDLE) && req1_valid && (grant == 1'b1);
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequencer.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        ctl_d        = ctl_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
`ifdef ALU_ARB_ERR_EN
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ctl_d  = sel_ctl;
                    a_d    = sel_a;
                    b_d    = sel_b;
                    id_d   = grant;
                    last_d = grant;
`ifdef ALU_ARB_ERR_EN
                    if (sel_ctl == CTL_UNSUPPORTED) begin
                        // Answer immediately without occupying the ALU.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        result_d     = '0;
                        zero_d       = 1'b1;
                        err_d        = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
`else
                    state_d = ST_EXEC;
`endif
                end
            end
            ST_EXEC: begin
                // ALU inputs have been stable for the whole cycle; sample now.
                result_d     = alu_out;
                zero_d       = alu_zero;
`ifdef ALU_ARB_ERR_EN
                err_d        = 1'b0;
`endif
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            ctl_q        <= CTL_UNSUPPORTED;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
`ifdef ALU_ARB_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            ctl_q        <= ctl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
`ifdef ALU_ARB_ERR_EN
            err_q        <= err_d;
`endif
        end
    end

    // All outputs other than the readies come straight from flops.
    always_comb begin
        alu_ctl     = ctl_q;
        alu_a       = a_q;
        alu_b       = b_q;
        resp_valid  = resp_valid_q;
        resp_id     = id_q;
        resp_result = result_q;
        resp_zero   = zero_q;
`ifdef ALU_ARB_ERR_EN
        resp_err    = err_q;
`else
        resp_err    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural MIPS ALU on the alu_* port, and a
// scoreboard of expected responses filled at acceptance time.
`timescale 1ns/1ps

module tb_alu_arbiter;

    localparam int W = 32;
`ifdef ALU_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [5:0]   req0_funct, req1_funct;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [W-1:0] resp_result;
    logic [3:0]   alu_ctl;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_zero;

    typedef struct packed {
        logic         id;
        logic [W-1:0] result;
        logic         zero;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Shared combinational MIPSALU
    always_comb begin
        case (alu_ctl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd7:    alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    // Expected response computed from the function code itself.
    function automatic exp_t model(input logic id, input logic [5:0] f,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (f)
            6'd32:   e.result = a + b;
            6'd34:   e.result = a - b;
            6'd36:   e.result = a & b;
            6'd37:   e.result = a | b;
            6'd39:   e.result = ~(a | b);
            6'd42:   e.result = (a < b) ? 32'd1 : 32'd0;
            default: begin e.result = '0; e.err = ERR_EN; end
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    // Present a request and wait for its handshake; queue the expectation.
    task automatic drive_req(input logic id, input logic [5:0] f,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             output int waited);
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_funct = f; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_funct = f; req0_a = a; req0_b = b; end
        waited = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        if (waited < 20) sb.push_back(model(id, f, a, b));
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Count negedges from just after acceptance until resp_valid appears.
    task automatic collect_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!resp_valid && lat < 20);
    endtask

    task automatic test_reset;
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        n_vec++;
        if ({resp_valid, req0_ready, req1_ready, resp_id, resp_result, resp_zero, resp_err, alu_ctl, alu_a, alu_b}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd15, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_values: got valid=%b rdy=%b%b id=%b res=%h z=%b err=%b ctl=%0d a=%h b=%h required all 0 with ctl=15",
                     resp_valid, req0_ready, req1_ready, resp_id, resp_result, resp_zero, resp_err, alu_ctl, alu_a, alu_b);
        end
        $display("reset: outputs checked under reset");
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add;
        int w, lat; exp_t e;
        resp_ready = 1'b1;
        drive_req(1'b0, 6'd32, 32'd7, 32'd5, w);
        n_vec++; if (w >= 20) begin n_err++; $display("FAIL add_accept: req0_ready never rose, waited %0d", w); end
        n_vec++; if (alu_ctl !== 4'd2) begin n_err++; $display("FAIL add_ctl: alu_ctl=%0d required 2", alu_ctl); end
        collect_resp(lat);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL add_latency: got %0d required 2", lat); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_vec++;
        if ({resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.result, e.zero, e.err}) begin
            n_err++;
            $display("FAIL add_resp: got id=%b res=%0d z=%b err=%b required id=%b res=%0d z=%b err=%b",
                     resp_id, resp_result, resp_zero, resp_err, e.id, e.result, e.zero, e.err);
        end
        $display("add: id=%b res=%0d zero=%b lat=%0d", resp_id, resp_result, resp_zero, lat);
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL add_drain: resp_valid=%b required 0", resp_valid); end
    endtask

    task automatic test_backpressure;
        int w, lat; exp_t e;
        resp_ready = 1'b0;
        drive_req(1'b1, 6'd42, 32'd3, 32'd6, w);
        n_vec++; if (w >= 20) begin n_err++; $display("FAIL slt_accept: req1_ready never rose, waited %0d", w); end
        collect_resp(lat);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL slt_latency: got %0d required 2", lat); end
        req0_valid = 1'b1; req0_funct = 6'd32; req1_valid = 1'b1; req1_funct = 6'd32;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_vec++;
            if ({resp_valid, resp_id, resp_result, req0_ready, req1_ready} !== {1'b1, 1'b1, 32'd1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL slt_hold[%0d]: got valid=%b id=%b res=%0d rdy=%b%b required valid=1 id=1 res=1 rdy=00",
                         i, resp_valid, resp_id, resp_result, req0_ready, req1_ready);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_vec++;
        if ({resp_valid, resp_id, resp_result, resp_zero, resp_err, req0_ready, req1_ready}
            !== {1'b1, e.id, e.result, e.zero, e.err, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL slt_resp: got valid=%b id=%b res=%0d z=%b err=%b rdy=%b%b required valid=1 id=%b res=%0d z=%b err=%b rdy=00",
                     resp_valid, resp_id, resp_result, resp_zero, resp_err, req0_ready, req1_ready,
                     e.id, e.result, e.zero, e.err);
        end
        $display("slt: held 5 cycles, id=%b res=%0d", resp_id, resp_result);
        @(negedge clk); #1;
        n_vec++;
        if ({resp_valid, req0_ready, req1_ready} !== {1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL slt_return_idle: got valid=%b rdy=%b%b required valid=0 rdy=10",
                     resp_valid, req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        int ngrant, nresp, last_c;
        logic g; exp_t e;
        ngrant = 0; nresp = 0; last_c = 0;
        resp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_funct = 6'd34; req0_a = 32'd9;  req0_b = 32'd9;
        req1_valid = 1'b1; req1_funct = 6'd36; req1_a = 32'hA;  req1_b = 32'hC;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (resp_valid) begin
                e = (sb.size() > 0) ? sb.pop_front() : '0;
                n_vec++;
                if ({resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.result, e.zero, e.err}) begin
                    n_err++;
                    $display("FAIL rr_resp[%0d]: got id=%b res=%0d z=%b err=%b required id=%b res=%0d z=%b err=%b",
                             nresp, resp_id, resp_result, resp_zero, resp_err, e.id, e.result, e.zero, e.err);
                end
                $display("rr: resp %0d id=%b res=%0d zero=%b", nresp, resp_id, resp_result, resp_zero);
                nresp++;
            end
            if (ngrant < 4 && (req0_ready || req1_ready)) begin
                g = req1_ready;
                n_vec++;
                if (g !== ngrant[0]) begin
                    n_err++;
                    $display("FAIL rr_grant[%0d]: granted %b required %b", ngrant, g, ngrant[0]);
                end
                if (ngrant > 0) begin
                    n_vec++;
                    if (c - last_c != 3) begin
                        n_err++;
                        $display("FAIL rr_spacing[%0d]: got %0d cycles required 3", ngrant, c - last_c);
                    end
                end
                last_c = c;
                sb.push_back(g ? model(1'b1, 6'd36, 32'hA, 32'hC) : model(1'b0, 6'd34, 32'd9, 32'd9));
                ngrant++;
                if (ngrant == 4) begin
                    @(posedge clk); #1;
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end
            end
        end
        n_vec++;
        if (nresp != 4 || ngrant != 4) begin
            n_err++;
            $display("FAIL rr_count: got %0d grants %0d responses required 4 and 4", ngrant, nresp);
        end
    endtask

    task automatic test_logic_ops;
        int w, lat; exp_t e;
        logic [5:0]   fn [2];
        logic [W-1:0] av [2];
        logic [W-1:0] bv [2];
        fn[0] = 6'd39; av[0] = 32'd0; bv[0] = 32'd0;
        fn[1] = 6'd37; av[1] = 32'd1; bv[1] = 32'd2;
        resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b0, fn[i], av[i], bv[i], w);
            collect_resp(lat);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_vec++;
            if (w >= 20 || lat != 2 ||
                {resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.result, e.zero, e.err}) begin
                n_err++;
                $display("FAIL logic_op[funct=%0d]: wait=%0d lat=%0d id=%b res=%h z=%b err=%b required lat=2 id=%b res=%h z=%b err=%b",
                         fn[i], w, lat, resp_id, resp_result, resp_zero, resp_err, e.id, e.result, e.zero, e.err);
            end
            $display("logic: funct=%0d res=%h zero=%b", fn[i], resp_result, resp_zero);
            @(negedge clk);
        end
    endtask

    task automatic test_unsupported;
        int w, lat; exp_t e;
        logic [3:0] ctl_seen;
        resp_ready = 1'b1;
        drive_req(1'b0, 6'h3F, 32'd5, 32'd9, w);
        ctl_seen = alu_ctl;
        collect_resp(lat);
        n_vec++;
        if (lat != (ERR_EN ? 1 : 2)) begin
            n_err++;
            $display("FAIL bad_latency: got %0d required %0d", lat, ERR_EN ? 1 : 2);
        end
        if (!ERR_EN) begin
            n_vec++;
            if (ctl_seen !== 4'd15) begin n_err++; $display("FAIL bad_ctl: alu_ctl=%0d required 15", ctl_seen); end
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_vec++;
        if ({resp_id, resp_result, resp_zero, resp_err} !== {e.id, e.result, e.zero, e.err}) begin
            n_err++;
            $display("FAIL bad_resp: got id=%b res=%h z=%b err=%b required id=%b res=%h z=%b err=%b",
                     resp_id, resp_result, resp_zero, resp_err, e.id, e.result, e.zero, e.err);
        end
        $display("unsupported: lat=%0d res=%h zero=%b err=%b", lat, resp_result, resp_zero, resp_err);
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int w, lat;
        resp_ready = 1'b1;
        // Reset while the operation is in EXEC.
        drive_req(1'b0, 6'd32, 32'h11, 32'h22, w);
        n_vec++; if (alu_ctl !== 4'd2) begin n_err++; $display("FAIL exec_before_reset: alu_ctl=%0d required 2", alu_ctl); end
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_vec++;
        if ({resp_valid, req0_ready, req1_ready, resp_result, alu_ctl, alu_a, alu_b}
            !== {1'b0, 1'b0, 1'b0, 32'd0, 4'd15, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_exec: got valid=%b rdy=%b%b res=%h ctl=%0d a=%h b=%h required 0 0 0 0 15 0 0",
                     resp_valid, req0_ready, req1_ready, resp_result, alu_ctl, alu_a, alu_b);
        end
        sb.delete();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL dropped_exec[%0d]: resp_valid=%b required 0", i, resp_valid); end
        end
        $display("reset in EXEC: operation dropped");
        // Reset while a response is waiting in RESP.
        resp_ready = 1'b0;
        drive_req(1'b0, 6'd32, 32'd1, 32'd2, w);
        collect_resp(lat);
        n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL resp_before_reset: resp_valid=%b required 1", resp_valid); end
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        n_vec++;
        if ({resp_valid, req0_ready, req1_ready, resp_id, resp_result, resp_zero, resp_err, alu_ctl, alu_a, alu_b}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd15, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_resp: got valid=%b rdy=%b%b id=%b res=%h z=%b err=%b ctl=%0d a=%h b=%h required all 0 with ctl=15",
                     resp_valid, req0_ready, req1_ready, resp_id, resp_result, resp_zero, resp_err, alu_ctl, alu_a, alu_b);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL first_grant_after_reset: rdy=%b%b required 10", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL dropped_resp[%0d]: resp_valid=%b required 0", i, resp_valid); end
        end
        $display("reset in RESP: response dropped, requester 0 granted first");
    endtask

    initial begin
        reset = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b0; req0_funct = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_funct = '0; req1_a = '0; req1_b = '0;
        test_reset;
        test_add;
        test_backpressure;
        test_round_robin;
        test_logic_ops;
        test_unsupported;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
